if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the RISC-V pipeline. Owns the PC and issues word fetches to instruction memory.
- Buffers returned instructions in a 2-entry queue that feeds the IF/ID boundary.
- Consumes the execute stage's branch_taken/branch_target: redirects the PC, flushes buffered instructions and discards in-flight responses.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/if_fetch_fifo.sv | 56 +++++
 rtl/if_fetch_unit.sv | 115 +++++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants, fetch payload type and fetch FSM encoding.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned FETCH_FIFO_DEPTH = 2;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Major opcodes shared by the decode and ALU stages
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry {pc, instr} queue between the fetch engine and the IF/ID boundary.
module if_fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push_ok;
    logic         pop_ok;

    // Guard against misuse so the occupancy never leaves 0..2
    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues one word fetch at a time and queues responses
// for IF/ID; a taken branch redirects, flushes and discards the in-flight fetch.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_instr,
    output logic        IF_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         discard_q, discard_d;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    fetch_entry_t fifo_wdata;
    fetch_entry_t fifo_head;
    logic [1:0]   fifo_count;
    logic         head_valid;

    assign head_valid = (fifo_count != 2'd0);
    assign fifo_wdata = '{pc: req_pc_q, instr: imem_rdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        imem_req   = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                // Issue only when the queue can absorb the response
                imem_req = !reset && !branch_taken && (32'(fifo_count) < FIFO_DEPTH);
                if (imem_req && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_d = FETCH_IDLE;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        fifo_push = !branch_taken;
                    end
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        fifo_pop = head_valid && !stall && !branch_taken;

        // Redirect overrides everything; a still-pending response is marked stale
        if (branch_taken) begin
            fetch_pc_d = branch_target;
            fifo_flush = 1'b1;
            if (state_q == FETCH_WAIT && !imem_rvalid) begin
                discard_d = 1'b1;
            end
        end
    end

    if_fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign imem_addr = fetch_pc_q;
    assign IF_valid  = head_valid;
    assign IF_PC     = head_valid ? fifo_head.pc    : 32'h0000_0000;
    assign IF_instr  = head_valid ? fifo_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + randomized bench for if_fetch_unit against a stream-level model:
// consumed instructions must be sequential from the last redirect target.
module tb_if_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] IF_PC;
    logic [31:0] IF_instr;
    logic        IF_valid;

    if_fetch_unit #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .IF_PC         (IF_PC),
        .IF_instr      (IF_instr),
        .IF_valid      (IF_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: occupancy, next PC to be consumed, next PC to fetch,
    // plus a single-slot memory with an epoch tag to recognise stale responses.
    int          m_count;
    logic [31:0] exp_next;
    logic [31:0] exp_fetch;
    bit          pend_v;
    logic [31:0] pend_addr;
    int          pend_epoch;
    int          pend_cnt;
    int          epoch = 0;
    bit          found;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_init();
        m_count   = 0;
        exp_next  = TB_RESET_PC;
        exp_fetch = TB_RESET_PC;
        pend_v    = 1'b0;
        pend_cnt  = 0;
        epoch++;
    endtask

    task automatic drive_idle();
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        stall         = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
    endtask

    // One clock: drive, check against the model, advance the model, step.
    task automatic cycle(input logic br, input logic [31:0] tgt, input logic stl,
                         input logic g, input int lat);
        logic rv, exp_req, granted, popping;
        rv            = pend_v && (pend_cnt == 0);
        branch_taken  = br;
        branch_target = tgt;
        stall         = stl;
        imem_gnt      = g;
        imem_rvalid   = rv;
        imem_rdata    = rv ? memfn(pend_addr) : $urandom;
        #1;
        exp_req = !pend_v && !br && (m_count < 2);
        chk("if_valid", 32'(IF_valid), 32'(m_count != 0));
        if (m_count == 0) begin
            chk("if_pc_empty", IF_PC, 32'h0);
            chk("if_instr_empty", IF_instr, NOP_INSTR);
        end else begin
            chk("if_pc", IF_PC, exp_next);
            chk("if_instr", IF_instr, memfn(exp_next));
        end
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);

        granted = exp_req && g;
        popping = (m_count != 0) && !stl && !br;
        if (rv) pend_v = 1'b0;
        else if (pend_v) pend_cnt--;
        if (br) begin
            m_count   = 0;
            exp_next  = tgt;
            exp_fetch = tgt;
            epoch++;
        end else begin
            if (popping) begin
                m_count--;
                exp_next = exp_next + 32'd4;
            end
            if (rv && pend_epoch == epoch) m_count++;
            if (granted) begin
                pend_v     = 1'b1;
                pend_addr  = exp_fetch;
                pend_epoch = epoch;
                pend_cnt   = lat - 1;
                exp_fetch  = exp_fetch + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(IF_valid), 32'h0);
        chk({tag, "_instr"}, IF_instr, NOP_INSTR);
        chk({tag, "_pc"}, IF_PC, 32'h0);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1'b1;
        drive_idle();
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();

        // Steady stream with a 1-cycle memory
        for (int i = 0; i < 14; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Hold stall until the queue is full, then release
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("stall_full_valid", 32'(IF_valid), 32'h1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Redirect while a request is still outstanding
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (pend_v && pend_cnt > 0) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b0, 1'b1, 2);
        end
        chk("reach_wait", 32'(found), 32'h1);
        cycle(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Redirect in the same cycle as the response
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (pend_v && pend_cnt == 0) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);
        end
        chk("reach_rvalid", 32'(found), 32'h1);
        cycle(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Redirect together with stall and a coincident response
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (pend_v && pend_cnt == 0 && m_count != 0) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b1, 1'b1, 1);
        end
        chk("reach_stall_rvalid", 32'(found), 32'h1);
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1);
        chk("branch_flush_valid", 32'(IF_valid), 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // PC wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1);
        for (int i = 0; i < 14; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Asynchronous reset mid-cycle while a fetch is outstanding
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pend_v && m_count == 1) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);
        end
        chk("reach_wait_filled", 32'(found), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        model_init();
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Randomized traffic: stalls, grants, latencies and redirects
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0;
                default: tgt = $urandom & 32'h0000_FFFC;
            endcase
            cycle($urandom_range(0, 99) < 5, tgt, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 70, int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
